// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: issue/result bundle between the issue stage and multdiv_unit.
// The issue side drives the master modport; the unit owns the slave modport.
interface multdiv_unit_if;
  logic        valid;
  logic [6:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        hi_we;
  logic        lo_we;

  modport master (
    output valid, op, a, b, hi_in, lo_in, flush,
    input  busy, done, hi_out, lo_out, hi_we, lo_we
  );

  modport slave (
    input  valid, op, a, b, hi_in, lo_in, flush,
    output busy, done, hi_out, lo_out, hi_we, lo_we
  );
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit: HI/LO unit with a 2-stage 33x33 multiplier and a 32-step restoring divider.
// Define MULTDIV_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate stage.
module multdiv_unit (
  input logic           clk,
  input logic           reset,
  multdiv_unit_if.slave bus
);
  // decoded_op_t encodings of the ops this unit executes
  localparam logic [6:0] OpMult  = 7'h18;
  localparam logic [6:0] OpMultu = 7'h19;
  localparam logic [6:0] OpDiv   = 7'h1a;
  localparam logic [6:0] OpDivu  = 7'h1b;
  localparam logic [6:0] OpMadd  = 7'h1c;
  localparam logic [6:0] OpMaddu = 7'h1d;
  localparam logic [6:0] OpMsub  = 7'h1e;
  localparam logic [6:0] OpMsubu = 7'h1f;

  typedef enum logic [2:0] {
    StIdle, StMul, StDivPrep, StDiv, StDivFix, StDone
  } state_e;

  state_e      r_state;
  logic [6:0]  r_op;
  logic [32:0] r_a33, r_b33;
  logic [49:0] r_pl;
  logic [47:0] r_ph;
  logic [63:0] r_prod;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo, r_rem, r_dvs;
  logic        r_neg_q, r_neg_r;
  logic [31:0] r_hi_out, r_lo_out;
  logic        r_we;

  logic        w_is_mul, w_is_div, w_signed, w_done;
  logic [49:0] w_a50, w_bl50, w_pl;
  logic [47:0] w_a48, w_bh48, w_ph;
  logic [63:0] w_sum;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_diff;

  assign w_is_div = (bus.op == OpDiv) || (bus.op == OpDivu);
  assign w_signed = (bus.op == OpMult) || (bus.op == OpDiv) ||
                    (bus.op == OpMadd) || (bus.op == OpMsub);

`ifdef MULTDIV_MADD_EN
  logic [63:0] r_acc;
  logic        w_op_acc, w_r_acc;
  logic [63:0] w_acc_res;
  assign w_op_acc  = (bus.op == OpMadd) || (bus.op == OpMaddu) ||
                     (bus.op == OpMsub) || (bus.op == OpMsubu);
  assign w_r_acc   = (r_op == OpMadd) || (r_op == OpMaddu) ||
                     (r_op == OpMsub) || (r_op == OpMsubu);
  assign w_acc_res = ((r_op == OpMsub) || (r_op == OpMsubu)) ? r_acc - r_prod
                                                              : r_acc + r_prod;
  assign w_is_mul  = (bus.op == OpMult) || (bus.op == OpMultu) || w_op_acc;
`else
  assign w_is_mul  = (bus.op == OpMult) || (bus.op == OpMultu);
`endif

  // Stage 1 splits b into a signed high half and an unsigned low half; stage 2 recombines.
  assign w_a50  = {{17{r_a33[32]}}, r_a33};
  assign w_bl50 = {34'd0, r_b33[15:0]};
  assign w_pl   = w_a50 * w_bl50;
  assign w_a48  = {{15{r_a33[32]}}, r_a33};
  assign w_bh48 = {{31{r_b33[32]}}, r_b33[32:16]};
  assign w_ph   = w_a48 * w_bh48;
  assign w_sum  = {{14{r_pl[49]}}, r_pl} + {r_ph, 16'd0};

  // Dividend magnitude shifts out of r_quo while quotient bits shift in.
  assign w_rem_sh   = {r_rem, r_quo[31]};
  assign w_ge       = w_rem_sh >= {1'b0, r_dvs};
  assign w_rem_diff = w_rem_sh[31:0] - r_dvs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_op     <= 7'd0;
      r_a33    <= 33'd0;
      r_b33    <= 33'd0;
      r_pl     <= 50'd0;
      r_ph     <= 48'd0;
      r_prod   <= 64'd0;
      r_cnt    <= 5'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_dvs    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi_out <= 32'd0;
      r_lo_out <= 32'd0;
      r_we     <= 1'b0;
`ifdef MULTDIV_MADD_EN
      r_acc    <= 64'd0;
`endif
    end else if (bus.flush) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.valid) begin
            r_op  <= bus.op;
            r_a33 <= {w_signed & bus.a[31], bus.a};
            r_b33 <= {w_signed & bus.b[31], bus.b};
            r_cnt <= 5'd0;
`ifdef MULTDIV_MADD_EN
            r_acc <= {bus.hi_in, bus.lo_in};
`endif
            if (w_is_mul) begin
              r_state <= StMul;
            end else if (w_is_div) begin
              r_state <= StDivPrep;
            end else begin
              r_we    <= 1'b0;
              r_state <= StDone;
            end
          end
        end
        StMul: begin
          r_pl   <= w_pl;
          r_ph   <= w_ph;
          r_prod <= w_sum;
          r_cnt  <= r_cnt + 5'd1;
`ifdef MULTDIV_MADD_EN
          if ((r_cnt == 5'd2) || ((r_cnt == 5'd1) && !w_r_acc)) begin
            {r_hi_out, r_lo_out} <= w_r_acc ? w_acc_res : w_sum;
            r_we                 <= 1'b1;
            r_state              <= StDone;
          end
`else
          if (r_cnt == 5'd1) begin
            {r_hi_out, r_lo_out} <= w_sum;
            r_we                 <= 1'b1;
            r_state              <= StDone;
          end
`endif
        end
        StDivPrep: begin
          // r_a33[32]/r_b33[32] are the operand signs only for signed DIV
          r_quo   <= r_a33[32] ? 32'd0 - r_a33[31:0] : r_a33[31:0];
          r_dvs   <= r_b33[32] ? 32'd0 - r_b33[31:0] : r_b33[31:0];
          r_rem   <= 32'd0;
          r_neg_q <= r_a33[32] ^ r_b33[32];
          r_neg_r <= r_a33[32];
          r_cnt   <= 5'd0;
          r_state <= StDiv;
        end
        StDiv: begin
          r_rem <= w_ge ? w_rem_diff : w_rem_sh[31:0];
          r_quo <= {r_quo[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= StDivFix;
          end
        end
        StDivFix: begin
          r_hi_out <= r_neg_r ? 32'd0 - r_rem : r_rem;
          r_lo_out <= r_neg_q ? 32'd0 - r_quo : r_quo;
          r_we     <= 1'b1;
          r_state  <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Flush suppresses a completing result in the same cycle.
  assign w_done     = (r_state == StDone) && !bus.flush;
  assign bus.busy   = (r_state != StIdle);
  assign bus.done   = w_done;
  assign bus.hi_we  = w_done && r_we;
  assign bus.lo_we  = w_done && r_we;
  assign bus.hi_out = r_hi_out;
  assign bus.lo_out = r_lo_out;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed and randomized checks of multdiv_unit against a behavioural model.
// Honours MULTDIV_MADD_EN the same way as the design.
module tb_multdiv_unit;
  localparam logic [6:0] OpMult  = 7'h18;
  localparam logic [6:0] OpMultu = 7'h19;
  localparam logic [6:0] OpDiv   = 7'h1a;
  localparam logic [6:0] OpDivu  = 7'h1b;
  localparam logic [6:0] OpMadd  = 7'h1c;
  localparam logic [6:0] OpMaddu = 7'h1d;
  localparam logic [6:0] OpMsub  = 7'h1e;
  localparam logic [6:0] OpMsubu = 7'h1f;
`ifdef MULTDIV_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  multdiv_unit_if bus ();
  multdiv_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done = 0;
  logic [6:0] ops [0:7];

  // Model state: one outstanding op, its completion cycle and the held HI/LO.
  bit          m_active = 1'b0;
  bit          m_real = 1'b0;
  int          m_done_cyc = 0;
  logic [63:0] m_res = 64'd0;
  logic [63:0] m_hold = 64'd0;
  logic        exp_done;

  function automatic bit is_acc(input logic [6:0] op);
    return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic bit is_real(input logic [6:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu) ||
           (MaddEn && is_acc(op));
  endfunction

  function automatic int lat_of(input logic [6:0] op);
    if (!is_real(op)) return 1;
    if ((op == OpDiv) || (op == OpDivu)) return 35;
    if (is_acc(op)) return 4;
    return 3;
  endfunction

  function automatic logic [63:0] model_result(input logic [6:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
    longint sa, sb, qq, rr;
    logic [63:0] ps, pu, acc;
    logic [31:0] q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = sa * sb;
    pu  = {32'd0, a} * {32'd0, b};
    acc = {hi, lo};
    case (op)
      OpMult:  return ps;
      OpMultu: return pu;
      OpMadd:  return acc + ps;
      OpMaddu: return acc + pu;
      OpMsub:  return acc - ps;
      OpMsubu: return acc - pu;
      OpDiv, OpDivu: begin
        if (b == 32'd0) begin
          q = ((op == OpDiv) && a[31]) ? 32'd1 : 32'hffff_ffff;
          r = a;
        end else if (op == OpDiv) begin
          qq = sa / sb;
          rr = sa % sb;
          q  = qq[31:0];
          r  = rr[31:0];
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_hold   <= 64'd0;
    end else begin
      cyc <= cyc + 1;
      if (bus.flush) begin
        m_active <= 1'b0;
      end else if (m_active) begin
        if (cyc == m_done_cyc) m_active <= 1'b0;
      end else if (bus.valid) begin
        m_active   <= 1'b1;
        m_done_cyc <= cyc + lat_of(bus.op);
        m_real     <= is_real(bus.op);
        m_res      <= model_result(bus.op, bus.a, bus.b, bus.hi_in, bus.lo_in);
      end
      if (!bus.flush && m_active && m_real && (cyc + 1 == m_done_cyc)) m_hold <= m_res;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  assign exp_done = m_active && (cyc == m_done_cyc) && !bus.flush;

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 64'(bus.busy), 64'(m_active));
      chk("done", 64'(bus.done), 64'(exp_done));
      chk("we", {62'd0, bus.hi_we, bus.lo_we}, {62'd0, {2{exp_done && m_real}}});
      chk("hilo", {bus.hi_out, bus.lo_out}, m_hold);
    end
  end

  always @(negedge clk or posedge reset) begin
    if (reset) n_done <= 0;
    else if (bus.done) n_done <= n_done + 1;
  end

  task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    bus.valid = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.hi_in = hi;
    bus.lo_in = lo;
  endtask

  // Drops valid after the accept cycle and waits (bounded) for done.
  task automatic finish_op(input string name, input int t, input int exp_lat,
                           input logic [63:0] exp_res, input bit exp_we);
    int lat;
    logic [63:0] got;
    logic [1:0] we;
    lat = -1;
    got = 64'd0;
    we  = 2'b00;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - t;
        got = {bus.hi_out, bus.lo_out};
        we  = {bus.hi_we, bus.lo_we};
        break;
      end
    end
    chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({name, ".res"}, got, exp_res);
    chk({name, ".we"}, {62'd0, we}, {62'd0, {2{exp_we}}});
  endtask

  task automatic run_op(input string name, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int exp_lat, input logic [63:0] exp_res, input bit exp_we);
    int t;
    @(posedge clk); #1;
    drive(op, a, b, hi, lo);
    t = cyc;
    finish_op(name, t, exp_lat, exp_res, exp_we);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0;
    ops = '{OpMult, OpMultu, OpDiv, OpDivu, OpMadd, OpMaddu, OpMsub, OpMsubu};
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    drive(7'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.we", {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
    chk("rst.hilo", {bus.hi_out, bus.lo_out}, 64'd0);

    run_op("mult", OpMult, 32'hffff_fffe, 32'd3, 0, 0, 3, 64'hffff_ffff_ffff_fffa, 1);
    run_op("divu", OpDivu, 32'd100, 32'd7, 0, 0, 35, {32'd2, 32'd14}, 1);
    run_op("div_neg", OpDiv, 32'hffff_fff9, 32'd2, 0, 0, 35, {32'hffff_ffff, 32'hffff_fffd}, 1);
    run_op("div_zero", OpDiv, 32'd5, 32'd0, 0, 0, 35, {32'd5, 32'hffff_ffff}, 1);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hffff_ffff, 0, 0, 35, {32'd0, 32'h8000_0000}, 1);
    if (MaddEn) run_op("maddu", OpMaddu, 1, 1, 0, 32'hffff_ffff, 4, {32'd1, 32'd0}, 1);
    else run_op("maddu", OpMaddu, 1, 1, 0, 32'hffff_ffff, 1, {32'd0, 32'h8000_0000}, 0);

    // Flush a divide mid-flight, then issue a multiply the very next cycle.
    @(posedge clk); #1;
    drive(OpDivu, 32'd1000, 32'd3, 0, 0);
    t  = cyc;
    d0 = n_done;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    chk("flush.cyc", 64'(cyc - t), 64'd10);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush.busy", 64'(bus.busy), 64'd0);
    chk("flush.nodone", 64'(n_done - d0), 64'd0);
    drive(OpMultu, 32'hffff_ffff, 32'd2, 0, 0);
    finish_op("flush.multu", t, 14, {32'd1, 32'hffff_fffe}, 1);

    // valid held high through a divide: only the first request is taken.
    @(posedge clk); #1;
    drive(OpDivu, 32'd1000, 32'd10, 0, 0);
    t  = cyc;
    d0 = n_done;
    for (int k = 1; k < 35; k++) begin
      @(posedge clk); #1;
      drive(OpMult, $urandom, $urandom, 0, 0);
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
    @(negedge clk);
    chk("vhold.done", 64'(bus.done), 64'd1);
    chk("vhold.res", {bus.hi_out, bus.lo_out}, {32'd0, 32'd100});
    repeat (4) @(posedge clk);
    #1;
    chk("vhold.count", 64'(n_done - d0), 64'd1);
    chk("vhold.busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    drive(OpDivu, 32'hffff_ffff, 32'd3, 0, 0);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst.busy", 64'(bus.busy), 64'd0);
    chk("arst.done", 64'(bus.done), 64'd0);
    chk("arst.we", {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
    chk("arst.hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_op("post_rst", OpMult, 32'd7, 32'd6, 0, 0, 3, 64'd42, 1);

    // Random traffic: issues, ignored requests, nops and flushes, checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.valid = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 59) == 0);
      bus.op    = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      bus.a     = rand_word();
      bus.b     = rand_word();
      bus.hi_in = $urandom;
      bus.lo_in = $urandom;
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("drain.busy", 64'(bus.busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
